// File: rtl/booth_acc_collector.sv
// rtl/booth_acc_collector.sv - accumulates N Booth products into a saturating sum with a valid/ready output
module booth_acc_collector #(
    parameter int width = 8,
    parameter int N     = 4,
    parameter int ACC_W = 2*width+4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 done,
    input  logic [2*width-1:0]   M,
    input  logic                 clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_sum,
    output logic                 out_sat,
    output logic                 drop,
    output logic [7:0]           cnt
);

    // Index of the product that closes a sum.
    localparam logic [7:0] LAST_IDX = 8'(N-1);

    // Clamp values for the signed accumulator.
    localparam logic signed [ACC_W-1:0] SUM_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SUM_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Accumulator state.
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    sat_q, sat_d;

    // Output register state.
    logic                    out_valid_q, out_valid_d;
    logic signed [ACC_W-1:0] out_sum_q, out_sum_d;
    logic                    out_sat_q, out_sat_d;
    logic                    drop_q, drop_d;

    // Saturating adder datapath.
    logic signed [ACC_W-1:0] m_ext;
    logic signed [ACC_W-1:0] add_raw;
    logic signed [ACC_W-1:0] add_res;
    logic                    add_ovf;

    // Control decode.
    logic take;
    logic complete;
    logic load;
    logic discard;

    assign m_ext   = ACC_W'($signed(M));
    assign add_raw = acc_q + m_ext;

    // Overflow only when both addends share a sign and the result flips it.
    assign add_ovf = (acc_q[ACC_W-1] == m_ext[ACC_W-1]) &&
                     (add_raw[ACC_W-1] != acc_q[ACC_W-1]);
    assign add_res = add_ovf ? (acc_q[ACC_W-1] ? SUM_MIN : SUM_MAX) : add_raw;

    // clear wins over a coincident done; the product is dropped on purpose.
    assign take     = done && !clear;
    assign complete = take && (cnt_q == LAST_IDX);

    // The output slot is free if empty or being drained this very cycle.
    assign load    = complete && (!out_valid_q || out_ready);
    assign discard = complete && !load;

    // Next state of the accumulator, count and per-sum saturation flag.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (complete) begin
            acc_d = '0;
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (take) begin
            acc_d = add_res;
            cnt_d = cnt_q + 8'd1;
            sat_d = sat_q | add_ovf;
        end
    end

    // Next state of the output register, handshake and sticky drop flag.
    always_comb begin
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_sat_d   = out_sat_q;
        drop_d      = drop_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_sum_d   = add_res;
            out_sat_d   = sat_q | add_ovf;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (discard) begin
            drop_d = 1'b1;
        end
    end

    // Accumulator registers; reset discards any partial sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    // Output registers; drop is released only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_sat_q   <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_sat_q   <= out_sat_d;
            drop_q      <= drop_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_sat   = out_sat_q;
    assign drop      = drop_q;
    assign cnt       = cnt_q;

endmodule

// File: tb/tb_booth_acc_collector.sv
// tb/tb_booth_acc_collector.sv - self-checking bench for booth_acc_collector
module tb_booth_acc_collector;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        done = 1'b0;
    logic [15:0] M = '0;
    logic        clear = 1'b0;
    logic        out_ready = 1'b0;

    logic        a_valid, a_sat, a_drop;
    logic [19:0] a_sum;
    logic [7:0]  a_cnt;
    logic        b_valid, b_sat, b_drop;
    logic [15:0] b_sum;
    logic [7:0]  b_cnt;
    logic        c_valid, c_sat, c_drop;
    logic [19:0] c_sum;
    logic [7:0]  c_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    booth_acc_collector #(.width(8), .N(4), .ACC_W(20)) u_a (
        .clk(clk), .rst_n(rst_n), .done(done), .M(M), .clear(clear),
        .out_valid(a_valid), .out_ready(out_ready), .out_sum(a_sum),
        .out_sat(a_sat), .drop(a_drop), .cnt(a_cnt));

    booth_acc_collector #(.width(8), .N(4), .ACC_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .done(done), .M(M), .clear(clear),
        .out_valid(b_valid), .out_ready(out_ready), .out_sum(b_sum),
        .out_sat(b_sat), .drop(b_drop), .cnt(b_cnt));

    booth_acc_collector #(.width(8), .N(2), .ACC_W(20)) u_c (
        .clk(clk), .rst_n(rst_n), .done(done), .M(M), .clear(clear),
        .out_valid(c_valid), .out_ready(out_ready), .out_sum(c_sum),
        .out_sat(c_sat), .drop(c_drop), .cnt(c_cnt));

    typedef struct {
        bit     d;
        int     m;
        bit     clr;
        bit     rdy;
        bit     ev;
        longint es;
        bit     esat;
        bit     edrop;
        int     ecnt;
    } vec_t;

    // Reference model state, index 0 = u_a, index 1 = u_b.
    longint macc[2];
    int     mcnt[2];
    bit     msat[2];
    bit     mvalid[2];
    longint msum[2];
    bit     mosat[2];
    bit     mdrop[2];

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            macc[k] = 0; mcnt[k] = 0; msat[k] = 0;
            mvalid[k] = 0; msum[k] = 0; mosat[k] = 0; mdrop[k] = 0;
        end
    endtask

    // Sum-level behaviour: integer add with clamping, N products per sum.
    task automatic model_step(input int k, input int n, input int aw,
                              input bit d, input longint mv, input bit clr, input bit rdy);
        longint mx;
        longint mn;
        longint s;
        bit     ov;
        bit     was_valid;
        mx = (longint'(1) << (aw-1)) - 1;
        mn = -(longint'(1) << (aw-1));
        was_valid = mvalid[k];
        if (was_valid && rdy) mvalid[k] = 0;
        if (clr) begin
            macc[k] = 0; mcnt[k] = 0; msat[k] = 0;
        end else if (d) begin
            s  = macc[k] + mv;
            ov = 0;
            if (s > mx) begin s = mx; ov = 1; end
            else if (s < mn) begin s = mn; ov = 1; end
            if (mcnt[k] == n-1) begin
                if (!was_valid || rdy) begin
                    mvalid[k] = 1;
                    msum[k]   = s;
                    mosat[k]  = msat[k] | ov;
                end else begin
                    mdrop[k] = 1;
                end
                macc[k] = 0; mcnt[k] = 0; msat[k] = 0;
            end else begin
                macc[k] = s;
                mcnt[k] = mcnt[k] + 1;
                msat[k] = msat[k] | ov;
            end
        end
    endtask

    task automatic do_reset();
        done = 0; clear = 0; M = '0;
        rst_n = 0;
        cycle();
        cycle();
        rst_n = 1;
        cycle();
        model_reset();
    endtask

    task automatic pulse(input int v);
        done = 1;
        M = 16'(v);
        cycle();
        done = 0;
        M = '0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        logic [15:0] r16;
        bit rd, rc, rr;

        // Reset state
        done = 0; clear = 0; M = '0; rst_n = 0;
        cycle();
        chk("rst_valid", a_valid, 0);
        chk("rst_sum", longint'($signed(a_sum)), 0);
        chk("rst_sat", a_sat, 0);
        chk("rst_drop", a_drop, 0);
        chk("rst_cnt", a_cnt, 0);
        rst_n = 1;
        cycle();
        model_reset();

        // Basic four-product sum on u_a, spaced and back-to-back pulses
        tbl[0] = '{1, 15,     0, 1, 0, 0,     0, 0, 1};
        tbl[1] = '{0, 0,      0, 1, 0, 0,     0, 0, 1};
        tbl[2] = '{1, -14,    0, 1, 0, 0,     0, 0, 2};
        tbl[3] = '{1, 16129,  0, 1, 0, 0,     0, 0, 3};
        tbl[4] = '{1, 16384,  0, 1, 1, 32514, 0, 0, 0};
        tbl[5] = '{0, 12345,  0, 1, 0, 0,     0, 0, 0};
        tbl[6] = '{0, 0,      0, 0, 0, 0,     0, 0, 0};
        out_ready = 1;
        for (int i = 0; i < 7; i++) begin
            done = tbl[i].d; M = 16'(tbl[i].m); clear = tbl[i].clr; out_ready = tbl[i].rdy;
            cycle();
            chk($sformatf("tbl%0d_valid", i), a_valid, tbl[i].ev);
            chk($sformatf("tbl%0d_cnt", i), a_cnt, tbl[i].ecnt);
            chk($sformatf("tbl%0d_drop", i), a_drop, tbl[i].edrop);
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_sum", i), longint'($signed(a_sum)), tbl[i].es);
                chk($sformatf("tbl%0d_sat", i), a_sat, tbl[i].esat);
            end
        end
        done = 0; clear = 0;

        // Saturation on the 16-bit accumulator
        do_reset();
        out_ready = 1;
        pulse(16384); pulse(16384); pulse(-5); pulse(0);
        chk("sat_valid", b_valid, 1);
        chk("sat_sum", longint'($signed(b_sum)), 32762);
        chk("sat_flag", b_sat, 1);
        pulse(1); pulse(1); pulse(1); pulse(1);
        chk("sat_next_sum", longint'($signed(b_sum)), 4);
        chk("sat_next_flag", b_sat, 0);

        // N=2 output full: second sum is dropped
        do_reset();
        out_ready = 0;
        pulse(100); pulse(200);
        chk("full_valid1", c_valid, 1);
        chk("full_sum1", longint'($signed(c_sum)), 300);
        pulse(7); pulse(8);
        chk("full_sum_hold", longint'($signed(c_sum)), 300);
        chk("full_valid_hold", c_valid, 1);
        chk("full_drop", c_drop, 1);
        out_ready = 1;
        cycle();
        chk("full_valid_fall", c_valid, 0);
        chk("full_drop_sticky", c_drop, 1);
        out_ready = 0;

        // N=2 accept and reload in the same cycle
        do_reset();
        out_ready = 0;
        pulse(100); pulse(200);
        chk("reload_sum1", longint'($signed(c_sum)), 300);
        pulse(7);
        done = 1; M = 16'd8; out_ready = 1;
        cycle();
        done = 0; M = '0;
        chk("reload_valid", c_valid, 1);
        chk("reload_sum", longint'($signed(c_sum)), 15);
        chk("reload_drop", c_drop, 0);
        cycle();
        chk("reload_valid_fall", c_valid, 0);
        out_ready = 0;

        // clear with coincident done
        do_reset();
        out_ready = 1;
        pulse(50); pulse(60);
        chk("clr_cnt_before", a_cnt, 2);
        done = 1; M = 16'd70; clear = 1;
        cycle();
        done = 0; clear = 0; M = '0;
        chk("clr_cnt", a_cnt, 0);
        chk("clr_valid", a_valid, 0);
        pulse(1); pulse(2); pulse(3); pulse(4);
        chk("clr_valid_after", a_valid, 1);
        chk("clr_sum", longint'($signed(a_sum)), 10);
        chk("clr_sat", a_sat, 0);

        // Asynchronous reset mid-cycle
        do_reset();
        out_ready = 0;
        pulse(1); pulse(1); pulse(1); pulse(1);
        chk("arst_pre_valid", a_valid, 1);
        pulse(1); pulse(1);
        pulse(5); pulse(6);
        chk("arst_pre_drop", a_drop, 1);
        #2;
        rst_n = 0;
        #1;
        chk("arst_valid", a_valid, 0);
        chk("arst_sum", longint'($signed(a_sum)), 0);
        chk("arst_drop", a_drop, 0);
        chk("arst_cnt", a_cnt, 0);
        chk("arst_sat", a_sat, 0);
        cycle();
        rst_n = 1;
        cycle();
        out_ready = 1;
        pulse(-1); pulse(-1); pulse(-1); pulse(-1);
        chk("arst_after_valid", a_valid, 1);
        chk("arst_after_sum", longint'($signed(a_sum)), -4);

        // Randomized run against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rd  = ($urandom % 3) == 0;
            r16 = 16'($urandom);
            rc  = ($urandom % 40) == 0;
            rr  = ($urandom % 2) == 1;
            done = rd; M = r16; clear = rc; out_ready = rr;
            model_step(0, 4, 20, rd, longint'($signed(r16)), rc, rr);
            model_step(1, 4, 16, rd, longint'($signed(r16)), rc, rr);
            cycle();
            chk("rand_a_valid", a_valid, mvalid[0]);
            chk("rand_a_cnt", a_cnt, mcnt[0]);
            chk("rand_a_drop", a_drop, mdrop[0]);
            chk("rand_b_valid", b_valid, mvalid[1]);
            chk("rand_b_cnt", b_cnt, mcnt[1]);
            chk("rand_b_drop", b_drop, mdrop[1]);
            if (mvalid[0]) begin
                chk("rand_a_sum", longint'($signed(a_sum)), msum[0]);
                chk("rand_a_sat", a_sat, mosat[0]);
            end
            if (mvalid[1]) begin
                chk("rand_b_sum", longint'($signed(b_sum)), msum[1]);
                chk("rand_b_sat", b_sat, mosat[1]);
            end
        end
        done = 0; clear = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_acc_collector.md
Name: booth_acc_collector

Overview:
- Downstream consumer of the sequential Booth multiplier (booth_mult).
- Captures each signed product on the multiplier's one-cycle done pulse and accumulates N consecutive products into a signed sum (dot-product / MAC tail).
- Presents each completed sum on a valid/ready output port, with saturation and dropped-result flags.

Parameters:
- width, 8, operand width of the upstream multiplier; product input is 2*width bits signed.
- N, 4, products per accumulated sum; legal range 1..255.
- ACC_W, 2*width+4, accumulator/output width in bits; must be >= 2*width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- done  input  1  product strobe from multiplier; one-cycle pulse.
- M  input  2*width  signed two's-complement product, valid when done=1.
- clear  input  1  synchronous abort of the sum in progress.
- out_valid  output  1  completed sum available.
- out_ready  input  1  downstream accepts the sum.
- out_sum  output  ACC_W  signed accumulated sum.
- out_sat  output  1  saturation occurred while forming out_sum.
- drop  output  1  sticky: a completed sum was discarded because the output was full.
- cnt  output  8  number of products accumulated in the current sum.

Behaviour:
- Reset (async, rst_n=0): acc=0, cnt=0, internal sat flag=0, out_valid=0, out_sum=0, out_sat=0, drop=0. Takes effect immediately, including mid-sum; the partial sum is lost.
- Product extension: M is sign-extended to ACC_W before each add.
- Saturating add: if the signed add overflows, the result clamps to +(2^(ACC_W-1)-1) or -2^(ACC_W-1), and the per-sum sat flag is set.
- Per done=1 cycle with clear=0:
  - If cnt < N-1: acc <= sat_add(acc, M); cnt++.
  - If cnt == N-1 (sum completes): the final value sat_add(acc, M) and its sat flag go to the output register; acc=0, cnt=0, sat flag=0 the next cycle.
  - With N=1, every done completes a sum.
- Output register load on completion:
  - If out_valid=0, or (out_valid=1 and out_ready=1) in the same cycle: load out_sum/out_sat and set out_valid=1.
  - Otherwise (output full, not accepted): discard the new sum, set drop=1, and leave out_sum/out_sat/out_valid unchanged.
- Handshake:
  - out_valid=1 and out_ready=1 with no completion that cycle: out_valid falls next cycle.
  - out_sum is stable while out_valid=1 and out_ready=0.
- Latency: out_valid rises on the clock edge after the completing done cycle (1 cycle).
- clear=1: acc, cnt and sat flag go to 0; any done in the same cycle is ignored.
  - The output register and handshake are unaffected.
  - drop is cleared only by reset.
- done cycles with clear=0 are never lost by the accumulator, regardless of output state; accumulation continues while the output is stalled.
- done pulses arrive at most once per 4 cycles (multiplier period). The block must still operate correctly with back-to-back done.
- done=0 cycles: M is ignored.

Test Plan:
- width=8, N=4, ACC_W=20; products 15, -14, 16129, 16384 via done pulses, out_ready=1 -> out_valid one cycle after the 4th pulse, out_sum=32514, out_sat=0, cnt back to 0.
- ACC_W=16, N=4; products 16384, 16384, -5, 0 -> out_sum=32762 (32767 after the saturating second add, then -5), out_sat=1.
- N=2, out_ready=0; complete sum (100+200=300), then second sum (7+8=15) -> out_sum stays 300, drop=1. Raise out_ready -> 300 accepted, out_valid falls.
- N=2, out_valid=1 holding 300; out_ready=1 in the same cycle the next sum 15 completes -> out_sum=15, out_valid stays 1, drop=0.
- N=4; after two products (50, 60), clear=1 coincident with a done carrying 70 -> cnt=0; next four products 1,2,3,4 -> out_sum=10.
- After two products, assert rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately. After release, four products of -1 -> out_sum=-4.
